// File: rtl/hashgen_pkg.sv
`default_nettype none
// =============================================================================
// Package  : hashgen_pkg
// Purpose  : Scheduler state encoding, hash/target widths and the single
//            definition of the target check.
// Revision : 1.0
// =============================================================================

package hashgen_pkg;

    localparam int HASH_W = 24;
    localparam int TGT_W  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Both upper bytes must be strictly below the target; the low byte is ignored.
    function automatic logic hit(input logic [HASH_W-1:0] hash,
                                 input logic [TGT_W-1:0]  target);
        return (hash[23:16] < target) && (hash[15:8] < target);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nonce_scheduler_target_check.sv
`default_nettype none
// =============================================================================
// Module   : target_check
// Purpose  : Combinational hit detect of one hash result against the target.
// Revision : 1.0
// =============================================================================

module target_check
    import hashgen_pkg::*;
(
    input  logic [HASH_W-1:0] hash,
    input  logic [TGT_W-1:0]  target,
    output logic              is_hit
);

    assign is_hit = hit(hash, target);

endmodule

`default_nettype wire

// File: rtl/nonce_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : nonce_scheduler
// Purpose  : Walks a nonce range through the hash core, stopping on the first
//            target hit, on range exhaustion or on abort.
//            Optional core watchdog: define NONCE_SCHED_WDOG_EN.
// Revision : 1.0
// =============================================================================

module nonce_scheduler #(
    parameter int NONCE_W  = 32,
    parameter int HASH_W   = 24,
    parameter int TGT_W    = 8,
    parameter int WDOG_CYC = 255
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_base,
    input  logic [NONCE_W-1:0] nonce_count,
    input  logic [TGT_W-1:0]   target,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hash,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [HASH_W-1:0]  bounty,
    output logic [NONCE_W-1:0] bounty_nonce,
    output logic               wdog_err
);
    import hashgen_pkg::*;

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    state_t             r_state;
    logic [NONCE_W-1:0] r_cur;
    logic [NONCE_W-1:0] r_remaining;
    logic [TGT_W-1:0]   r_target;
    logic [HASH_W-1:0]  r_hash;
    logic               r_core_start;
    logic               r_busy;
    logic               r_found;
    logic               r_exhausted;
    logic [HASH_W-1:0]  r_bounty;
    logic [NONCE_W-1:0] r_bounty_nonce;
    logic               w_hit;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    target_check u_target_check (
        .hash   (r_hash),
        .target (r_target),
        .is_hit (w_hit)
    );

`ifdef NONCE_SCHED_WDOG_EN
    localparam int c_WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_wdog_err;
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state        <= IDLE;
            r_cur          <= '0;
            r_remaining    <= '0;
            r_target       <= '0;
            r_hash         <= '0;
            r_core_start   <= 1'b0;
            r_busy         <= 1'b0;
            r_found        <= 1'b0;
            r_exhausted    <= 1'b0;
            r_bounty       <= '0;
            r_bounty_nonce <= '0;
`ifdef NONCE_SCHED_WDOG_EN
            r_wdog         <= '0;
            r_wdog_err     <= 1'b0;
`endif
        end else if (abort) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cur       <= nonce_base;
                        r_remaining <= nonce_count;
                        r_target    <= target;
                        r_found     <= 1'b0;
                        r_exhausted <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef NONCE_SCHED_WDOG_EN
                        r_wdog_err  <= 1'b0;
`endif
                        if (nonce_count == '0) begin
                            r_exhausted <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_core_start <= 1'b1;
                            r_state      <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
`ifdef NONCE_SCHED_WDOG_EN
                    r_wdog  <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        r_hash  <= core_hash;
                        r_state <= CHECK;
                    end
`ifdef NONCE_SCHED_WDOG_EN
                    else if (r_wdog == c_WDOG_W'(WDOG_CYC - 1)) begin
                        r_wdog_err <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_wdog <= r_wdog + c_WDOG_W'(1);
                    end
`endif
                end
                CHECK: begin
                    if (w_hit) begin
                        r_bounty       <= r_hash;
                        r_bounty_nonce <= r_cur;
                        r_found        <= 1'b1;
                        r_state        <= DONE;
                    end else if (r_remaining == NONCE_W'(1)) begin
                        r_exhausted <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cur        <= r_cur + NONCE_W'(1);
                        r_remaining  <= r_remaining - NONCE_W'(1);
                        r_core_start <= 1'b1;
                        r_state      <= LAUNCH;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign core_start   = r_core_start;
    assign core_nonce   = r_cur;
    assign busy         = r_busy;
    assign found        = r_found;
    assign exhausted    = r_exhausted;
    assign bounty       = r_bounty;
    assign bounty_nonce = r_bounty_nonce;

`ifdef NONCE_SCHED_WDOG_EN
    assign wdog_err = r_wdog_err;
`else
    // WDOG_CYC only matters when the watchdog is built in.
    assign wdog_err = 1'b0 & (WDOG_CYC != 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_nonce_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_nonce_scheduler
// Purpose  : Directed vector bench for nonce_scheduler with a simple core model.
// Revision : 1.0
// =============================================================================

module tb_nonce_scheduler;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        start;
    logic        abort;
    logic [31:0] nonce_base;
    logic [31:0] nonce_count;
    logic [7:0]  target;
    logic        core_start;
    logic [31:0] core_nonce;
    logic        core_done;
    logic [23:0] core_hash;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic [23:0] bounty;
    logic [31:0] bounty_nonce;
    logic        wdog_err;

    int n_total = 0;
    int n_bad   = 0;

    int          lat         = 1;
    bit          core_silent = 1'b0;
    int          launches    = 0;
    logic [31:0] nonce_log[$];
    logic [23:0] hash_q[$];

    nonce_scheduler #(
        .NONCE_W  (32),
        .HASH_W   (24),
        .TGT_W    (8),
        .WDOG_CYC (8)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .start        (start),
        .abort        (abort),
        .nonce_base   (nonce_base),
        .nonce_count  (nonce_count),
        .target       (target),
        .core_start   (core_start),
        .core_nonce   (core_nonce),
        .core_done    (core_done),
        .core_hash    (core_hash),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .bounty       (bounty),
        .bounty_nonce (bounty_nonce),
        .wdog_err     (wdog_err)
    );

    always #5 clk = ~clk;

    // Hash core model: answers lat cycles after each launch with the next queued hash.
    initial begin
        core_done = 1'b0;
        core_hash = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                launches++;
                nonce_log.push_back(core_nonce);
                if (!core_silent) begin
                    repeat (lat) @(negedge clk);
                    core_hash = (hash_q.size() > 0) ? hash_q.pop_front() : 24'hFFFFFF;
                    core_done = 1'b1;
                    @(negedge clk);
                    core_done = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [31:0]      base;
        logic [31:0]      count;
        logic [7:0]       tgt;
        logic [3:0][23:0] hashes;   // [0] is returned first
        int               lat;
        logic             exp_found;
        logic             exp_exh;
        logic [23:0]      exp_bounty;
        logic [31:0]      exp_bnonce;
        int               exp_launches;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] c, input logic [7:0] t);
        @(negedge clk);
        nonce_base  = b;
        nonce_count = c;
        target      = t;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic wait_launch();
        for (int k = 0; k < 20 && launches == 0; k++) @(negedge clk);
        chk("launch_seen", 64'(launches), 64'd1);
    endtask

    task automatic run_job(input int idx, input vec_t v);
        int    cyc;
        string p;
        p = $sformatf("job%0d", idx);
        hash_q.delete();
        nonce_log.delete();
        for (int i = 0; i < 4; i++) hash_q.push_back(v.hashes[i]);
        lat      = v.lat;
        launches = 0;
        pulse_start(v.base, v.count, v.tgt);
        wait_idle(cyc);
        chk({p, " busy_cycles"}, 64'(cyc), 64'(v.exp_launches * (2 + v.lat) + 1));
        chk({p, " busy"}, 64'(busy), 64'd0);
        chk({p, " found"}, 64'(found), 64'(v.exp_found));
        chk({p, " exhausted"}, 64'(exhausted), 64'(v.exp_exh));
        chk({p, " wdog_err"}, 64'(wdog_err), 64'd0);
        chk({p, " bounty"}, 64'(bounty), 64'(v.exp_bounty));
        chk({p, " bounty_nonce"}, 64'(bounty_nonce), 64'(v.exp_bnonce));
        chk({p, " launches"}, 64'(launches), 64'(v.exp_launches));
        for (int i = 0; i < nonce_log.size() && i < 4; i++) begin
            logic [31:0] e;
            e = v.base + 32'(i);
            chk($sformatf("%s nonce%0d", p, i), 64'(nonce_log[i]), 64'(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc;

        vecs[0] = '{32'h10, 32'd4, 8'h40, {24'h203000, 24'h305000, 24'h900000, 24'h800000},
                    1, 1'b1, 1'b0, 24'h203000, 32'h13, 4};
        vecs[1] = '{32'h100, 32'd3, 8'hFF, {24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF},
                    2, 1'b0, 1'b1, 24'h203000, 32'h13, 3};
        vecs[2] = '{32'hFFFFFFFE, 32'd3, 8'h01, {24'h0, 24'h010100, 24'h000100, 24'h010000},
                    1, 1'b0, 1'b1, 24'h203000, 32'h13, 3};
        vecs[3] = '{32'h7, 32'd2, 8'hFF, {24'h0, 24'h0, 24'hFEFEFF, 24'hFF0000},
                    3, 1'b1, 1'b0, 24'hFEFEFF, 32'h8, 2};
        vecs[4] = '{32'h20, 32'd2, 8'h00, {24'h0, 24'h0, 24'h000000, 24'h000000},
                    1, 1'b0, 1'b1, 24'hFEFEFF, 32'h8, 2};
        vecs[5] = '{32'h55, 32'd0, 8'h80, {24'h0, 24'h0, 24'h0, 24'h0},
                    1, 1'b0, 1'b1, 24'hFEFEFF, 32'h8, 0};
        vecs[6] = '{32'hABCD, 32'd5, 8'h10, {24'h0, 24'h0, 24'h0, 24'h0F0FFF},
                    2, 1'b1, 1'b0, 24'h0F0FFF, 32'hABCD, 1};
        vecs[7] = '{32'h30, 32'd3, 8'h40, {24'h0, 24'h3F3FAA, 24'h004000, 24'h403F00},
                    1, 1'b1, 1'b0, 24'h3F3FAA, 32'h32, 3};

        reset_L     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        nonce_base  = '0;
        nonce_count = '0;
        target      = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst core_start", 64'(core_start), 64'd0);
        chk("rst core_nonce", 64'(core_nonce), 64'd0);
        chk("rst found", 64'(found), 64'd0);
        chk("rst exhausted", 64'(exhausted), 64'd0);
        chk("rst bounty", 64'(bounty), 64'd0);
        chk("rst bounty_nonce", 64'(bounty_nonce), 64'd0);
        chk("rst wdog_err", 64'(wdog_err), 64'd0);
        reset_L = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) run_job(i, vecs[i]);

        // Abort in WAIT with a late core_done; a start pulse while busy is dropped.
        hash_q.delete();
        hash_q.push_back(24'h000000);
        lat      = 4;
        launches = 0;
        pulse_start(32'h50, 32'd2, 8'hFF);
        wait_launch();
        nonce_base = 32'h999;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start core_nonce", 64'(core_nonce), 64'h50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        repeat (8) @(negedge clk);
        chk("abort found", 64'(found), 64'd0);
        chk("abort exhausted", 64'(exhausted), 64'd0);
        chk("abort late_done busy", 64'(busy), 64'd0);
        chk("abort launches", 64'(launches), 64'd1);
        chk("abort bounty", 64'(bounty), 64'h3F3FAA);
        chk("abort bounty_nonce", 64'(bounty_nonce), 64'h32);

        // start and abort together: job not accepted.
        launches = 0;
        @(negedge clk);
        nonce_base  = 32'h1;
        nonce_count = 32'd1;
        start       = 1'b1;
        abort       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("start_abort launches", 64'(launches), 64'd0);

`ifdef NONCE_SCHED_WDOG_EN
        core_silent = 1'b1;
        launches    = 0;
        pulse_start(32'h5, 32'd1, 8'hFF);
        wait_idle(cyc);
        chk("wdog busy_cycles", 64'(cyc), 64'd10);
        chk("wdog wdog_err", 64'(wdog_err), 64'd1);
        chk("wdog found", 64'(found), 64'd0);
        chk("wdog exhausted", 64'(exhausted), 64'd0);
        chk("wdog launches", 64'(launches), 64'd1);
        core_silent = 1'b0;
`else
        chk("nowdog wdog_err", 64'(wdog_err), 64'd0);
`endif

        // Reset asserted mid-WAIT clears outputs without waiting for a clock edge.
        hash_q.delete();
        lat      = 6;
        launches = 0;
        pulse_start(32'h77, 32'd2, 8'hFF);
        wait_launch();
        @(negedge clk);
        chk("pre_rst busy", 64'(busy), 64'd1);
        #2 reset_L = 1'b0;
        #1;
        chk("async_rst busy", 64'(busy), 64'd0);
        chk("async_rst core_nonce", 64'(core_nonce), 64'd0);
        chk("async_rst bounty", 64'(bounty), 64'd0);
        chk("async_rst bounty_nonce", 64'(bounty_nonce), 64'd0);
        chk("async_rst found", 64'(found), 64'd0);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
